// File: rtl/muldiv_sequencer.sv
// Multi-cycle mul/div/mod sequencer beside the EX-stage ALU; optional MULDIV_FAST_MUL_EN gives single-cycle mul.
// Latency: WIDTH+1 cycles iterative, 1 cycle for divide-by-zero (and for mul with MULDIV_FAST_MUL_EN).
// Backpressure: holds the pipeline with stall from accept through RUN; result is a 1-cycle done pulse.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       alusignals,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             busy
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [4:0] OPC_MUL = 5'b00010;
    localparam logic [4:0] OPC_DIV = 5'b00011;
    localparam logic [4:0] OPC_MOD = 5'b00100;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_DIV, OP_MOD} op_t;

    state_t             state_q, state_d;
    op_t                op_q, op_d, accept_op;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               dbz_q, dbz_d;

    logic               is_muldiv, accept, b_zero, last_iter;
    logic [WIDTH-1:0]   a_mag, b_mag, mul_acc, div_rem, div_quo;
    logic [WIDTH:0]     rem_sh, diff;

    always_comb begin
        is_muldiv = (alusignals == OPC_MUL) || (alusignals == OPC_DIV) || (alusignals == OPC_MOD);
        // rst_n gating keeps stall low while reset is held with an instruction still presented
        accept    = start && is_muldiv && (state_q == ST_IDLE) && !flush && rst_n;
        case (alusignals)
            OPC_DIV: accept_op = OP_DIV;
            OPC_MOD: accept_op = OP_MOD;
            default: accept_op = OP_MUL;
        endcase
        a_mag     = op_a[WIDTH-1] ? -op_a : op_a;
        b_mag     = op_b[WIDTH-1] ? -op_b : op_b;
        b_zero    = (op_b == '0);
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));

        mul_acc   = acc_q + (mplier_q[0] ? mcand_q : '0);
        // Restoring step: dividend bits shift out of mplier_q, quotient bits shift in
        rem_sh    = {acc_q, mplier_q[WIDTH-1]};
        diff      = rem_sh - {1'b0, mcand_q};
        div_rem   = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        div_quo   = {mplier_q[WIDTH-2:0], ~diff[WIDTH]};
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = accept_op;
                    cnt_d   = '0;
                    acc_d   = '0;
                    dbz_d   = 1'b0;
                    q_neg_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    r_neg_d = op_a[WIDTH-1];
                    if (accept_op == OP_MUL) begin
                        mcand_d  = op_a;
                        mplier_d = op_b;
                    end else begin
                        mcand_d  = b_mag;
                        mplier_d = a_mag;
                    end
                    if (accept_op != OP_MUL && b_zero) begin
                        state_d  = ST_DONE;
                        dbz_d    = 1'b1;
                        result_d = (accept_op == OP_DIV) ? '1 : op_a;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (accept_op == OP_MUL) begin
                        state_d  = ST_DONE;
                        result_d = op_a * op_b;
`endif
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (op_q == OP_MUL) begin
                        acc_d    = mul_acc;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                    end else begin
                        acc_d    = div_rem;
                        mplier_d = div_quo;
                    end
                    if (last_iter) begin
                        state_d = ST_DONE;
                        case (op_q)
                            OP_MUL:  result_d = mul_acc;
                            OP_DIV:  result_d = q_neg_q ? -div_quo : div_quo;
                            default: result_d = r_neg_q ? -div_rem : div_rem;
                        endcase
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign stall       = accept || (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign result      = result_q;
    assign div_by_zero = dbz_q && (state_q == ST_DONE);
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle execute sequencer for the SimpleRISC `mul`, `div` and `mod` opcodes. It sits beside the single-cycle ALU in the EX stage and accepts an operation when the decoded ALU opcode selects one of these instructions. It computes the result iteratively and holds the pipeline with `stall` until the result is ready. It then presents the result for exactly one cycle, so the EX/MA register captures it on the cycle `stall` drops.

## Interface
- `WIDTH`, 32, operand/result width; iteration count equals `WIDTH`
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  EX stage holds a valid instruction
- `alusignals`  in  5  opcode field instruction[31:27]
- `op_a`  in  WIDTH  first operand (rs1)
- `op_b`  in  WIDTH  second operand (rs2 or immediate)
- `flush`  in  1  branch/interrupt flush of EX stage
- `stall`  out  1  freeze IF/ID/EX registers
- `done`  out  1  result valid this cycle (1-cycle pulse)
- `result`  out  WIDTH  product/quotient/remainder
- `div_by_zero`  out  1  qualifies `done`: divisor was zero
- `busy`  out  1  FSM not IDLE

## Operation
- Opcodes handled: `mul` 00010, `div` 00011, `mod` 00100. Any other opcode is ignored.
- `accept` = `start` & opcode∈{mul, div, mod} & state==IDLE & !`flush`.
- On `accept`:
  - latch the operands and the opcode;
  - clear the iteration counter;
  - go to RUN.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `accept`.
  - RUN→DONE after `WIDTH` iterations (counter reaches WIDTH-1).
  - DONE→IDLE unconditionally.
  - RUN→IDLE on `flush`.
- `mul`:
  - radix-2 shift-add, one bit per cycle;
  - `result` = low WIDTH bits of the product, so the signed result is correct modulo 2^WIDTH.
- `div`/`mod`:
  - signed two's-complement;
  - convert operands to magnitudes, then run restoring division, one quotient bit per cycle;
  - quotient sign = sign(a)^sign(b); remainder sign = sign(a); truncation is toward zero;
  - most-negative / -1: quotient = most-negative, remainder = 0 (wraps, no flag).
- Divide by zero (op_b==0 at accept):
  - RUN is skipped; the FSM goes IDLE→DONE directly;
  - `div` result = all-ones; `mod` result = op_a;
  - `div_by_zero`=1 during DONE.
- `start` while RUN/DONE is ignored. The pipeline is stalled in RUN, so the same instruction is still presented and must not restart.

## Timing
- Cycle 0 = the cycle in which `accept` is true.
- `stall` = `accept` | (state==RUN).
  - The stall is combinational in cycle 0, so the instruction is held.
  - `stall` is 0 in DONE and in IDLE otherwise.
- Iterative latency: RUN occupies cycles 1..WIDTH; DONE is cycle WIDTH+1 (cycle 33 for WIDTH=32).
  - `stall` is high for cycles 0..WIDTH.
  - `done`=1 and `result` is valid only in DONE.
- Divide-by-zero latency: DONE in cycle 1; `stall` is high in cycle 0 only.
- `result` holds its last value outside DONE. Consumers must qualify it with `done`.
- `flush`:
  - in RUN: abort at the next edge; state→IDLE, no `done`, `stall` drops the following cycle;
  - in DONE: ignored (the result is already released);
  - in IDLE together with `start`: no accept, no stall.
- A back-to-back muldiv instruction arriving in the cycle after DONE is accepted normally.
- Reset values: state=IDLE, `stall`=0, `done`=0, `busy`=0, `div_by_zero`=0, `result`=0, counter=0.
  - Reset asserted mid-RUN aborts immediately, asynchronously.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - `mul` uses a single-cycle combinational WIDTH×WIDTH multiplier (low half);
  - accept goes IDLE→DONE directly;
  - `stall` is high in cycle 0 only and `done` is in cycle 1.
  - `div`/`mod` are unchanged.
- `MULDIV_FAST_MUL_EN` undefined: `mul` is iterative with the WIDTH+1-cycle latency above.

## Test plan
- `mul` 7×6, macro undefined:
  - `stall` is high for cycles 0–32;
  - `done` in cycle 33 with `result`=42;
  - `div_by_zero`=0.
- `div` -7/2 → `result`=32'hFFFFFFFD (-3). `mod` -7,2 → `result`=32'hFFFFFFFF (-1). `mod` 7,-2 → 1.
- `div` 5/0:
  - `done` in cycle 1 with `result`=32'hFFFFFFFF and `div_by_zero`=1;
  - `mod` 5,0 → `result`=5.
- `mul` accepted, `flush` in cycle 10:
  - state is IDLE by cycle 11 and `stall`=0 in cycle 11;
  - no `done` pulse within the next 40 cycles.
- `start` with `add` (00000) or `ld` (01110) → `stall`, `busy` and `done` never assert.
- `rst_n` low in cycle 15 of a `div` → all outputs 0 immediately. After release, a fresh `mul` 3×3 → 9 at cycle 33.
